alu_seq_hs: RTL and testbench

//  Parametrised, registered successor to the 8-bit combinational ALU: WIDTH-bit

---
 rtl/alu_seq_hs.sv | 165 ++++++++++++++++
 tb/tb_alu_seq_hs.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_hs.sv
// Registered WIDTH-bit ALU with valid/ready handshakes on both sides, one op in flight.
// Define ALU_SEQ_MUL_EN to make mode 0111 an iterative shift-add multiplier.
module alu_seq_hs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [3:0]       alu_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zero,
  output logic             illegal
);

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_t;
  localparam int CW = $clog2(WIDTH);
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} state_t;
`endif

  state_t           r_state;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_zero;
  logic             r_illegal;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_illegal;
  logic             w_is_mul;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
`endif

  // Ready also drops combinationally while reset is held.
  assign in_ready = !rst && ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
  assign w_accept = in_valid && in_ready;

  assign w_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
  assign w_dif = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, ci};

  always_comb begin
    w_res     = '0;
    w_cout    = 1'b0;
    w_illegal = 1'b0;
    w_is_mul  = 1'b0;
    case (alu_mode)
      4'b0000: begin
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
      end
      4'b0001: begin
        // Bit WIDTH of the widened difference is set exactly when a < b+ci.
        w_res  = w_dif[WIDTH-1:0];
        w_cout = w_dif[WIDTH];
      end
      4'b0010: w_res = a & b;
      4'b0011: w_res = a | b;
      4'b0100: w_res = a ^ b;
      4'b0101: begin
        w_res  = {a[WIDTH-2:0], ci};
        w_cout = a[WIDTH-1];
      end
      4'b0110: begin
        w_res  = {ci, a[WIDTH-1:1]};
        w_cout = a[0];
      end
`ifdef ALU_SEQ_MUL_EN
      4'b0111: w_is_mul = 1'b1;
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_EXEC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == '0) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_s         <= w_acc_next[WIDTH-1:0];
            r_cout      <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_zero      <= (w_acc_next[WIDTH-1:0] == '0);
            r_illegal   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
`endif
        default: ;
      endcase

      // Accept only happens in IDLE or DONE, so this overrides the DONE release above.
      if (w_accept) begin
        if (w_is_mul) begin
`ifdef ALU_SEQ_MUL_EN
          r_state     <= ST_EXEC;
          r_out_valid <= 1'b0;
          r_acc       <= '0;
          r_mcand     <= {{WIDTH{1'b0}}, a};
          r_mplier    <= b;
          r_cnt       <= CW'(WIDTH - 1);
`endif
        end else begin
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
          r_s         <= w_res;
          r_cout      <= w_cout;
          r_zero      <= (w_res == '0);
          r_illegal   <= w_illegal;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign s         = r_s;
  assign cout      = r_cout;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_seq_hs.sv
// Bench for alu_seq_hs: directed literal checks plus randomized handshakes against
// a per-cycle reference model of result values and handshake timing.
module tb_alu_seq_hs;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic [3:0]   alu_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         zero;
  logic         illegal;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq_hs #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .alu_mode(alu_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .zero(zero), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         z;
    logic         ill;
    int           lat;
  } res_t;

  // Reference: results from plain integer arithmetic on the mode table.
  function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fci, input logic [3:0] fm);
    res_t r;
    longint unsigned ua, ub, md, t;
    ua = fa; ub = fb; md = 64'd1 << W;
    r.s = '0; r.c = 1'b0; r.ill = 1'b0; r.lat = 1;
    case (fm)
      4'd0: begin t = ua + ub + fci; r.s = W'(t % md); r.c = (t >= md); end
      4'd1: begin r.s = W'((ua + 2*md - ub - fci) % md); r.c = (ua < ub + fci); end
      4'd2: r.s = fa & fb;
      4'd3: r.s = fa | fb;
      4'd4: r.s = fa ^ fb;
      4'd5: begin r.s = W'((ua*2 + fci) % md); r.c = (ua >= md/2); end
      4'd6: begin r.s = W'(ua/2 + fci*(md/2)); r.c = (ua % 2 == 1); end
`ifdef ALU_SEQ_MUL_EN
      4'd7: begin t = ua * ub; r.s = W'(t % md); r.c = (t >= md); r.lat = W + 1; end
`endif
      default: r.ill = 1'b1;
    endcase
    r.z = (r.s == '0);
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: one outstanding result, visible from cycle m_due onward.
  int   m_cycle = 0;
  int   m_due   = 0;
  int   m_txn   = 0;
  logic m_pending;
  res_t m_exp;
  res_t m_now;
  logic m_valid;
  logic m_rdy;

  always_comb m_now = model(a, b, ci, alu_mode);
  assign m_valid = m_pending && (m_cycle >= m_due);
  assign m_rdy   = !rst && (!m_pending || (m_valid && out_ready));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending <= 1'b0;
    end else begin
      m_cycle <= m_cycle + 1;
      if (in_valid && m_rdy) begin
        m_pending <= 1'b1;
        m_exp     <= m_now;
        m_due     <= m_cycle + m_now.lat;
        m_txn     <= m_txn + 1;
        $display("txn %0d: mode=%b a=%h b=%h ci=%b -> s=%h cout=%b ill=%b lat=%0d",
                 m_txn, alu_mode, a, b, ci, m_now.s, m_now.c, m_now.ill, m_now.lat);
      end else if (m_valid && out_ready) begin
        m_pending <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
    end else begin
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("s", s, m_exp.s);
        chk("cout", cout, m_exp.c);
        chk("zero", zero, m_exp.z);
        chk("illegal", illegal, m_exp.ill);
      end
    end
  end

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tci, input logic [3:0] tm, input logic ordy,
                        input logic [W-1:0] es, input logic ec, input logic ez,
                        input logic eil, input int elat, output int waited);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tb_; ci = tci; alu_mode = tm; in_valid = 1'b1; out_ready = ordy;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) chk({nm, "_accept_timeout"}, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_; ci = ~tci;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_s"}, s, es);
    chk({nm, "_cout"}, cout, ec);
    chk({nm, "_zero"}, zero, ez);
    chk({nm, "_illegal"}, illegal, eil);
  endtask

  initial begin
    int w;
    logic [W-1:0] held_s;
    logic held_c, held_z;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ci = 1'b0; alu_mode = 4'd0;
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_s", s, 0);
    chk("reset_cout", cout, 0);
    chk("reset_zero", zero, 0);
    chk("reset_illegal", illegal, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1 chk("post_reset_in_ready", in_ready, 1);

    run_op("add", 8'hab, 8'hcb, 1'b0, 4'b0000, 1'b1, 8'h76, 1'b1, 1'b0, 1'b0, 1, w);
    run_op("sub", 8'hab, 8'hcb, 1'b0, 4'b0001, 1'b1, 8'he0, 1'b1, 1'b0, 1'b0, 1, w);
    run_op("and", 8'hab, 8'hcb, 1'b0, 4'b0010, 1'b1, 8'h8b, 1'b0, 1'b0, 1'b0, 1, w);
    run_op("or",  8'hab, 8'hcb, 1'b0, 4'b0011, 1'b1, 8'heb, 1'b0, 1'b0, 1'b0, 1, w);
    run_op("xor", 8'h6f, 8'he1, 1'b0, 4'b0100, 1'b1, 8'h8e, 1'b0, 1'b0, 1'b0, 1, w);
    run_op("shl", 8'h6f, 8'he1, 1'b1, 4'b0101, 1'b1, 8'hdf, 1'b0, 1'b0, 1'b0, 1, w);
    run_op("shr", 8'h6f, 8'he1, 1'b0, 4'b0110, 1'b1, 8'h37, 1'b1, 1'b0, 1'b0, 1, w);
`ifdef ALU_SEQ_MUL_EN
    run_op("mul", 8'h6f, 8'he1, 1'b0, 4'b0111, 1'b1, 8'h8f, 1'b1, 1'b0, 1'b0, W + 1, w);
`else
    run_op("mul_illegal", 8'h6f, 8'he1, 1'b0, 4'b0111, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1, w);
`endif
    run_op("add_wrap", 8'hff, 8'h01, 1'b0, 4'b0000, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1, w);
    run_op("mode_1010", 8'h12, 8'h34, 1'b1, 4'b1010, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1, w);
    run_op("clr_illegal", 8'hab, 8'hcb, 1'b0, 4'b0010, 1'b1, 8'h8b, 1'b0, 1'b0, 1'b0, 1, w);
    run_op("sub_borrow_ci", 8'h05, 8'h05, 1'b1, 4'b0001, 1'b1, 8'hff, 1'b1, 1'b0, 1'b0, 1, w);

    // Backpressure: result must hold while the consumer stalls.
    run_op("bp_add", 8'h40, 8'h21, 1'b1, 4'b0000, 1'b0, 8'h62, 1'b0, 1'b0, 1'b0, 1, w);
    held_s = s; held_c = cout; held_z = zero;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      chk("bp_hold_s", s, held_s);
      chk("bp_hold_cout", cout, held_c);
      chk("bp_hold_zero", zero, held_z);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    run_op("bp_next", 8'hab, 8'hcb, 1'b0, 4'b0011, 1'b1, 8'heb, 1'b0, 1'b0, 1'b0, 1, w);
    chk("bp_same_cycle_accept", w, 0);

    // Reset in the middle of a multiply (or an illegal held result without the multiplier).
    run_op("pre_rst", 8'hab, 8'hcb, 1'b0, 4'b0000, 1'b0, 8'h76, 1'b1, 1'b0, 1'b0, 1, w);
    @(posedge clk); #1;
    a = 8'h6f; b = 8'he1; ci = 1'b0; alu_mode = 4'b0111; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_s", s, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #3;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("after_rst_no_stale", out_valid, 0);
      chk("after_rst_in_ready", in_ready, 1);
    end

    // Randomized handshakes; the compare process checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 2) == 1;
      out_ready = ($urandom % 4) != 0;
      a = W'($urandom); b = W'($urandom); ci = $urandom % 2 == 1;
      alu_mode = 4'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("final_idle_out_valid", out_valid, 0);
    chk("final_idle_in_ready", in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
